// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(12,8) datapath blocks.
//   CODE_W          codeword width (8 data + 4 check bits)
//   DATA_W          payload width
//   FRAME_BITS_BASE serial frame length in bits without the parity bit
//                   (start + 12 code bits + stop)
//   tx_state_t      serializer FSM state encoding
package hamming_pkg;

  localparam int CODE_W          = 12;
  localparam int DATA_W          = 8;
  localparam int FRAME_BITS_BASE = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/hamming_baud_timer.sv
// Bit-period timer for the serial line.
//   clk      clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear; holds the counter at 0 while the line is idle
//   count    position inside the current bit period, 0..CLKS_PER_BIT-1
//   bit_end  last clock of the current bit period (never asserted while clr=1)
module hamming_baud_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Every bit boundary coincides with bit_end, so wrapping here also gives
  // the restart-on-state-change behaviour the FSM relies on.
  assign bit_end = !clr && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Serial transmitter for Hamming(12,8) codewords.
// Frame: start (0), code bits 0..11 LSB first, optional even parity, stop (1).
// A one-word holding register lets the next codeword be accepted while the
// current frame shifts out, so consecutive frames have no idle gap.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_code valid
//   in_ready   holding register empty (handshake when in_valid && in_ready)
//   in_code    12-bit codeword, bit 0 = Hamming position 1
//   tx_out     registered serial line, idle high
//   busy       frame in progress or word held
//   frame_done one-cycle pulse in the last clock of each stop bit
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t         state, state_nxt;
  logic              hold_full;
  logic [CODE_W-1:0] hold;
  logic [CODE_W-1:0] shifter, shifter_nxt;
  logic [3:0]        bit_idx;
  logic              par, par_nxt;
  logic              tx_nxt;
  logic              load, shift, accept;
  logic              bit_end;
  logic [CNT_W-1:0]  baud_cnt;

  hamming_baud_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ST_IDLE),
    .count   (baud_cnt),
    .bit_end (bit_end)
  );

  // in_ready depends on registered state only; load and accept can never
  // hit the same edge because accept requires the hold to be empty.
  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      tx_out    <= 1'b1;
    end else begin
      state  <= state_nxt;
      tx_out <= tx_nxt;
      if (accept) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        bit_idx <= '0;
      end else if (shift) begin
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= in_code;
    end
    shifter <= shifter_nxt;
    par     <= par_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bit_idx == 4'd11) begin
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (hold_full) begin
            load      = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. tx_out is computed from the next state and next shifter
  // contents so the registered line changes on the same edge as the state.
  always_comb begin
    shifter_nxt = shifter;
    par_nxt     = par;
    if (load) begin
      shifter_nxt = hold;
      par_nxt     = ^hold;
    end else if (shift) begin
      shifter_nxt = {1'b0, shifter[CODE_W-1:1]};
    end
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shifter_nxt[0];
      ST_PARITY: tx_nxt = par_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  assign busy       = (state != ST_IDLE) || hold_full;
  assign frame_done = (state == ST_STOP) && bit_end;

  // The baud counter must sit at zero whenever the line is idle so the
  // first start bit after a load lasts a full period.
  idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst_n)
                                  (state == ST_IDLE) |-> (baud_cnt == '0));

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer. Three instances cover
// CLKS_PER_BIT=4/no parity, CLKS_PER_BIT=4/parity, CLKS_PER_BIT=1/no parity;
// they share clock, reset and in_code, each has its own in_valid.
module tb_hamming_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  in_valid = 3'b000;
  logic [11:0] in_code = 12'h000;
  logic [2:0]  rdy, tx, bsy, fd;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  always #5 clk = ~clk;

  hamming_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_c4p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
    .in_code(in_code), .tx_out(tx[0]), .busy(bsy[0]), .frame_done(fd[0]));

  hamming_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_c4p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
    .in_code(in_code), .tx_out(tx[1]), .busy(bsy[1]), .frame_done(fd[1]));

  hamming_tx_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u_c1p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]),
    .in_code(in_code), .tx_out(tx[2]), .busy(bsy[2]), .frame_done(fd[2]));

  task automatic chk(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected line level at frame clock t (1 = first clock of start bit).
  function automatic logic exp_tx(input logic [11:0] code, input logic par,
                                  input int pen, input int cpb, input int t);
    int b;
    b = (t - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b <= 12) return code[b-1];
    if (b == 13 && pen != 0) return par;
    return 1'b1;
  endfunction

  task automatic run_frame(input int i, input int cpb, input int pen,
                           input logic [11:0] code, input logic par,
                           input string tag);
    int flen;
    flen = (14 + pen) * cpb;
    @(negedge clk);
    chk($sformatf("%s_rdy_pre", tag), rdy[i], 1'b1);
    in_valid[i] = 1'b1;
    in_code     = code;
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_code     = 12'h000;
    chk($sformatf("%s_tx_acc", tag), tx[i], 1'b1);
    chk($sformatf("%s_rdy_acc", tag), rdy[i], 1'b0);
    chk($sformatf("%s_busy_acc", tag), bsy[i], 1'b1);
    for (int t = 1; t <= flen; t++) begin
      @(negedge clk);
      chk($sformatf("%s_tx_%0d", tag, t), tx[i], exp_tx(code, par, pen, cpb, t));
      chk($sformatf("%s_fd_%0d", tag, t), fd[i], (t == flen));
      chk($sformatf("%s_busy_%0d", tag, t), bsy[i], 1'b1);
    end
    @(negedge clk);
    chk($sformatf("%s_tx_end", tag), tx[i], 1'b1);
    chk($sformatf("%s_busy_end", tag), bsy[i], 1'b0);
    chk($sformatf("%s_fd_end", tag), fd[i], 1'b0);
    chk($sformatf("%s_rdy_end", tag), rdy[i], 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("por_tx%0d", i), tx[i], 1'b1);
      chk($sformatf("por_rdy%0d", i), rdy[i], 1'b1);
      chk($sformatf("por_busy%0d", i), bsy[i], 1'b0);
      chk($sformatf("por_fd%0d", i), fd[i], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames, including parity and one-clock bits.
    run_frame(0, 4, 0, 12'hA47, 1'b0, "a47_c4");
    run_frame(1, 4, 1, 12'hA47, 1'b0, "a47_par");
    run_frame(1, 4, 1, 12'h001, 1'b1, "001_par");
    run_frame(2, 1, 0, 12'hFFF, 1'b0, "fff_c1");

    // Back-to-back frames with backpressure on the second word.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_code     = 12'hA47;
    @(negedge clk);
    chk("b2b_rdy_t0", rdy[0], 1'b0);
    in_code = 12'h5B8;
    for (int t = 1; t <= 113; t++) begin
      logic etx;
      @(negedge clk);
      if (t <= 56)       etx = exp_tx(12'hA47, 1'b0, 0, 4, t);
      else if (t <= 112) etx = exp_tx(12'h5B8, 1'b0, 0, 4, t - 56);
      else               etx = 1'b1;
      chk($sformatf("b2b_tx_%0d", t), tx[0], etx);
      chk($sformatf("b2b_rdy_%0d", t), rdy[0], (t == 1) || (t >= 57));
      chk($sformatf("b2b_fd_%0d", t), fd[0], (t == 56) || (t == 112));
      chk($sformatf("b2b_busy_%0d", t), bsy[0], (t <= 112));
      // Keep in_valid high with changing codes while the hold is full.
      if (t >= 2 && t < 10) in_code = 12'h3C3 ^ 12'(t);
      if (t == 10) begin
        in_valid[0] = 1'b0;
        in_code     = 12'h000;
      end
    end

    // Asynchronous reset mid-frame with a word held.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_code     = 12'hA47;
    @(negedge clk);
    in_code = 12'h5B8;
    @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("rst_pre_tx", tx[0], 1'b0);
    chk("rst_pre_rdy", rdy[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx[0], 1'b1);
    chk("rst_rdy", rdy[0], 1'b1);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_fd", fd[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      chk($sformatf("post_rst_tx_%0d", t), tx[0], 1'b1);
      chk($sformatf("post_rst_fd_%0d", t), fd[0], 1'b0);
      chk($sformatf("post_rst_busy_%0d", t), bsy[0], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
